// File: rtl/rtr_channel_input_chk.sv
// Receive-side router channel checker: unpacks channel words through an input
// pipeline and tracks per-VC packet framing, flagging violations in sticky bits.
module rtr_channel_input_chk #(
    parameter int unsigned num_vcs            = 4,
    // 0: TAIL_ONLY (unsupported), 1: HEAD_TAIL, 2: EXPLICIT_LENGTH
    parameter int unsigned packet_format      = 2,
    parameter int unsigned max_payload_length = 4,
    parameter int unsigned min_payload_length = 1,
    parameter int unsigned route_info_width   = 14,
    parameter int unsigned enable_link_pm     = 1,
    parameter int unsigned flit_data_width    = 64,
    parameter int unsigned num_pipe_stages    = 1,
    localparam int unsigned vc_idx_width  = (num_vcs > 1) ? $clog2(num_vcs) : 0,
    localparam int unsigned lpm_width     = (enable_link_pm != 0) ? 1 : 0,
    localparam int unsigned tail_width    = (packet_format == 1) ? 1 : 0,
    localparam int unsigned channel_width = lpm_width + 2 + vc_idx_width + tail_width + flit_data_width
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         active,
    input  logic [0:channel_width-1]     channel_in,
    input  logic                         error_clear,
    output logic                         flit_valid_out,
    output logic                         flit_head_out,
    output logic                         flit_tail_out,
    output logic [0:num_vcs-1]           flit_sel_out_ivc,
    output logic [0:num_vcs-1]           flit_tail_out_ivc,
    output logic [0:flit_data_width-1]   flit_data_out,
    output logic [0:num_vcs-1]           error_ivc,
    output logic                         error_event
);

    localparam int unsigned packet_format_head_tail       = 1;
    localparam int unsigned packet_format_explicit_length = 2;
    localparam bit          is_explicit = (packet_format == packet_format_explicit_length);

    localparam int unsigned vc_sw    = (vc_idx_width > 0) ? vc_idx_width : 1;
    localparam int unsigned len_span = max_payload_length - min_payload_length;
    localparam int unsigned plw      = $clog2(len_span + 1);
    localparam int unsigned plw_s    = (plw > 0) ? plw : 1;
    localparam int unsigned ctr_w    = $clog2(max_payload_length + 1);
    localparam int unsigned lst      = num_pipe_stages - 1;

    localparam int unsigned valid_pos = lpm_width;
    localparam int unsigned vc_pos    = lpm_width + 1;
    localparam int unsigned head_pos  = vc_pos + vc_idx_width;
    localparam int unsigned tail_pos  = head_pos + 1;
    localparam int unsigned data_pos  = head_pos + 1 + tail_width;

    typedef enum logic {IDLE = 1'b0, BODY = 1'b1} vc_state_t;

    // Reject configurations the framing logic cannot handle
    if (packet_format != packet_format_head_tail && packet_format != packet_format_explicit_length) begin : g_bad_format
        $error("rtr_channel_input_chk: unsupported packet_format %0d", packet_format);
    end
    if (num_pipe_stages < 1 || num_pipe_stages > 3) begin : g_bad_stages
        $error("rtr_channel_input_chk: num_pipe_stages must be 1..3");
    end
    if (num_vcs < 1 || max_payload_length < 1 || min_payload_length > max_payload_length) begin : g_bad_len
        $error("rtr_channel_input_chk: invalid num_vcs or payload length range");
    end

    logic                       in_valid, in_head, in_tail;
    logic [vc_sw-1:0]           in_vc;
    logic [0:flit_data_width-1] in_data;
    logic                       regs_active;

    assign in_valid = channel_in[valid_pos];
    assign in_head  = channel_in[head_pos];
    assign in_data  = channel_in[data_pos +: flit_data_width];

    if (vc_idx_width > 0) begin : g_vc_field
        assign in_vc = channel_in[vc_pos +: vc_idx_width];
    end else begin : g_no_vc_field
        assign in_vc = '0;
    end

    if (tail_width > 0) begin : g_tail_field
        assign in_tail = channel_in[tail_pos];
    end else begin : g_no_tail_field
        assign in_tail = 1'b0;
    end

    // Data stages only clock while the link is up
    if (enable_link_pm != 0) begin : g_link_pm
        logic link_active_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                link_active_q <= 1'b0;
            else if (active)
                link_active_q <= channel_in[0];
        end
        assign regs_active = link_active_q & active;
    end else begin : g_no_link_pm
        assign regs_active = active;
    end

    logic [0:num_pipe_stages-1] pipe_valid;
    logic [0:num_pipe_stages-1] pipe_head;
    logic [0:num_pipe_stages-1] pipe_tail;
    logic [vc_sw-1:0]           pipe_vc   [num_pipe_stages];
    logic [0:flit_data_width-1] pipe_data [num_pipe_stages];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_valid <= '0;
        end else if (active) begin
            pipe_valid[0] <= in_valid;
            for (int k = 1; k < num_pipe_stages; k++)
                pipe_valid[k] <= pipe_valid[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (regs_active) begin
            pipe_head[0] <= in_head;
            pipe_tail[0] <= in_tail;
            pipe_vc[0]   <= in_vc;
            pipe_data[0] <= in_data;
            for (int k = 1; k < num_pipe_stages; k++) begin
                pipe_head[k] <= pipe_head[k-1];
                pipe_tail[k] <= pipe_tail[k-1];
                pipe_vc[k]   <= pipe_vc[k-1];
                pipe_data[k] <= pipe_data[k-1];
            end
        end
    end

    logic                       head_l, tail_l;
    logic [vc_sw-1:0]           vc_l;
    logic [0:flit_data_width-1] data_l;

    assign head_l = pipe_head[lst];
    assign tail_l = pipe_tail[lst];
    assign vc_l   = pipe_vc[lst];
    assign data_l = pipe_data[lst];

    // Head length decode; out-of-range encodings fall back to the maximum
    logic [plw_s-1:0] enc;
    logic [ctr_w-1:0] enc_ext, hd_len;
    logic             len_err;

    if (plw > 0) begin : g_len_field
        assign enc = data_l[route_info_width +: plw];
    end else begin : g_no_len_field
        assign enc = '0;
    end

    assign enc_ext = ctr_w'(enc);
    assign len_err = (plw > 0) && (enc_ext > ctr_w'(len_span));
    assign hd_len  = len_err ? ctr_w'(max_payload_length) : ctr_w'(min_payload_length) + enc_ext;

    logic [0:num_vcs-1] sel, adv;

    always_comb begin
        sel = '0;
        adv = '0;
        for (int v = 0; v < num_vcs; v++) begin
            sel[v] = (vc_l == vc_sw'(v));
            adv[v] = pipe_valid[lst] & active & sel[v];
        end
    end

    vc_state_t        state_q [num_vcs];
    vc_state_t        state_d [num_vcs];
    logic [ctr_w-1:0] ctr_q   [num_vcs];
    logic [ctr_w-1:0] ctr_d   [num_vcs];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < num_vcs; v++) begin
                state_q[v] <= IDLE;
                ctr_q[v]   <= '0;
            end
        end else begin
            for (int v = 0; v < num_vcs; v++) begin
                state_q[v] <= state_d[v];
                ctr_q[v]   <= ctr_d[v];
            end
        end
    end

    // A head always (re)starts a packet; a stray body leaves the VC idle
    always_comb begin
        for (int v = 0; v < num_vcs; v++) begin
            state_d[v] = state_q[v];
            ctr_d[v]   = ctr_q[v];
            if (adv[v]) begin
                if (head_l) begin
                    if (is_explicit) begin
                        if (hd_len == '0) begin
                            state_d[v] = IDLE;
                            ctr_d[v]   = '0;
                        end else begin
                            state_d[v] = BODY;
                            ctr_d[v]   = hd_len - ctr_w'(1);
                        end
                    end else begin
                        state_d[v] = tail_l ? IDLE : BODY;
                    end
                end else if (state_q[v] == BODY) begin
                    if (is_explicit) begin
                        if (ctr_q[v] == '0)
                            state_d[v] = IDLE;
                        else
                            ctr_d[v] = ctr_q[v] - ctr_w'(1);
                    end else if (tail_l) begin
                        state_d[v] = IDLE;
                    end
                end
            end
        end
    end

    logic [0:num_vcs-1] tail_v, err_v, tail_ivc;

    always_comb begin
        tail_v   = '0;
        err_v    = '0;
        tail_ivc = '0;
        for (int v = 0; v < num_vcs; v++) begin
            tail_ivc[v] = is_explicit ? (state_q[v] == BODY && ctr_q[v] == '0) : tail_l;
            if (head_l) begin
                tail_v[v] = is_explicit ? (hd_len == '0) : tail_l;
                err_v[v]  = adv[v] & ((state_q[v] == BODY) | (is_explicit & len_err));
            end else if (state_q[v] == IDLE) begin
                tail_v[v] = 1'b1;
                err_v[v]  = adv[v];
            end else begin
                tail_v[v] = is_explicit ? (ctr_q[v] == '0) : tail_l;
            end
        end
    end

    logic [0:num_vcs-1] error_q;
    logic               event_q;

    // New errors win over a simultaneous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_q <= '0;
            event_q <= 1'b0;
        end else begin
            error_q <= ((error_clear & active) ? '0 : error_q) | err_v;
            event_q <= |err_v;
        end
    end

    assign flit_valid_out    = pipe_valid[lst];
    assign flit_head_out     = head_l;
    assign flit_tail_out     = |(tail_v & sel);
    assign flit_sel_out_ivc  = sel;
    assign flit_tail_out_ivc = tail_ivc;
    assign flit_data_out     = data_l;
    assign error_ivc         = error_q;
    assign error_event       = event_q;

endmodule

// File: tb/tb_rtr_channel_input_chk.sv
// Directed bench for rtr_channel_input_chk: explicit-length (1 and 3 stages,
// min=0 variant) and head/tail instances driven with hand-computed vectors.
module tb_rtr_channel_input_chk;

    typedef logic [0:68] el_word_t;
    typedef logic [0:69] ht_word_t;
    typedef logic [0:63] data_t;
    typedef logic [0:3]  vcv_t;

    logic clk = 1'b0;
    logic reset, active, error_clear;
    el_word_t ch_a, ch_b, ch_c;
    ht_word_t ch_d;

    logic a_valid, a_head, a_tail, a_evt; vcv_t a_sel, a_tivc, a_err; data_t a_data;
    logic b_valid, b_head, b_tail, b_evt; vcv_t b_sel, b_tivc, b_err; data_t b_data;
    logic c_valid, c_head, c_tail, c_evt; vcv_t c_sel, c_tivc, c_err; data_t c_data;
    logic d_valid, d_head, d_tail, d_evt; vcv_t d_sel, d_tivc, d_err; data_t d_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rtr_channel_input_chk #(.num_pipe_stages(1)) dut_a (
        .clk(clk), .reset(reset), .active(active), .channel_in(ch_a), .error_clear(error_clear),
        .flit_valid_out(a_valid), .flit_head_out(a_head), .flit_tail_out(a_tail),
        .flit_sel_out_ivc(a_sel), .flit_tail_out_ivc(a_tivc), .flit_data_out(a_data),
        .error_ivc(a_err), .error_event(a_evt));

    rtr_channel_input_chk #(.num_pipe_stages(3)) dut_b (
        .clk(clk), .reset(reset), .active(active), .channel_in(ch_b), .error_clear(error_clear),
        .flit_valid_out(b_valid), .flit_head_out(b_head), .flit_tail_out(b_tail),
        .flit_sel_out_ivc(b_sel), .flit_tail_out_ivc(b_tivc), .flit_data_out(b_data),
        .error_ivc(b_err), .error_event(b_evt));

    rtr_channel_input_chk #(.min_payload_length(0), .max_payload_length(2)) dut_c (
        .clk(clk), .reset(reset), .active(active), .channel_in(ch_c), .error_clear(error_clear),
        .flit_valid_out(c_valid), .flit_head_out(c_head), .flit_tail_out(c_tail),
        .flit_sel_out_ivc(c_sel), .flit_tail_out_ivc(c_tivc), .flit_data_out(c_data),
        .error_ivc(c_err), .error_event(c_evt));

    rtr_channel_input_chk #(.packet_format(1)) dut_d (
        .clk(clk), .reset(reset), .active(active), .channel_in(ch_d), .error_clear(error_clear),
        .flit_valid_out(d_valid), .flit_head_out(d_head), .flit_tail_out(d_tail),
        .flit_sel_out_ivc(d_sel), .flit_tail_out_ivc(d_tivc), .flit_data_out(d_data),
        .error_ivc(d_err), .error_event(d_evt));

    function automatic data_t mk_data(input int tag, input int enc);
        data_t d;
        d = '0;
        d[48:63] = 16'(tag);
        d[14:15] = 2'(enc);
        return d;
    endfunction

    function automatic el_word_t el_flit(input int vc, input logic head, input int enc, input int tag);
        return {1'b1, 1'b1, 2'(vc), head, mk_data(tag, enc)};
    endfunction

    function automatic el_word_t el_idle();
        return {1'b1, 1'b0, 2'b00, 1'b0, 64'h0};
    endfunction

    function automatic ht_word_t ht_flit(input int vc, input logic head, input logic tail, input int tag);
        return {1'b1, 1'b1, 2'(vc), head, tail, mk_data(tag, 0)};
    endfunction

    function automatic vcv_t onehot(input int vc);
        vcv_t v;
        v = '0;
        v[vc] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input el_word_t w);
        ch_a = w; step(); ch_a = el_idle();
    endtask

    task automatic send_c(input el_word_t w);
        ch_c = w; step(); ch_c = el_idle();
    endtask

    task automatic send_d(input ht_word_t w);
        ch_d = w; step(); ch_d = {1'b1, 69'h0};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if ({a_valid, b_valid, c_valid, d_valid} !== 4'b0000) begin
            errors++; $display("FAIL reset_valid got %b exp 0000", {a_valid, b_valid, c_valid, d_valid});
        end
        checks++;
        if ({a_err, b_err, c_err, d_err} !== 16'h0) begin
            errors++; $display("FAIL reset_error_ivc got %h exp 0000", {a_err, b_err, c_err, d_err});
        end
        checks++;
        if ({a_evt, b_evt, c_evt, d_evt} !== 4'b0000) begin
            errors++; $display("FAIL reset_error_event got %b exp 0000", {a_evt, b_evt, c_evt, d_evt});
        end
        reset = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_len3();
        for (int i = 0; i < 4; i++) begin
            send_a(el_flit(2, i == 0, 2, 10 + i));
            checks++;
            if ({a_valid, a_head, a_tail, a_sel} !== {1'b1, i == 0, i == 3, onehot(2)}) begin
                errors++; $display("FAIL len3_ctrl[%0d] got %b exp %b", i,
                    {a_valid, a_head, a_tail, a_sel}, {1'b1, i == 0, i == 3, onehot(2)});
            end
            checks++;
            if (a_data !== mk_data(10 + i, 2)) begin
                errors++; $display("FAIL len3_data[%0d] got %h exp %h", i, a_data, mk_data(10 + i, 2));
            end
            checks++;
            if (a_tivc !== ((i == 3) ? onehot(2) : 4'b0000)) begin
                errors++; $display("FAIL len3_tail_ivc[%0d] got %b", i, a_tivc);
            end
        end
        step();
        checks++;
        if ({a_err, a_evt} !== 5'b0) begin
            errors++; $display("FAIL len3_no_error got %b exp 00000", {a_err, a_evt});
        end
    endtask

    task automatic test_interleave();
        el_word_t   seq   [10];
        logic [0:5] exp_c [10];
        data_t      exp_d [10];
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) begin
                seq[i]   = el_flit(0, i % 4 == 0, 0, 20 + i);
                exp_c[i] = {i % 4 == 0, i % 4 == 2, onehot(0)};
                exp_d[i] = mk_data(20 + i, 0);
            end else begin
                seq[i]   = el_flit(3, i == 1, 3, 20 + i);
                exp_c[i] = {i == 1, i == 9, onehot(3)};
                exp_d[i] = mk_data(20 + i, 3);
            end
        end
        for (int cyc = 0; cyc < 12; cyc++) begin
            ch_b = (cyc < 10) ? seq[cyc] : el_idle();
            step();
            if (cyc < 2) begin
                checks++;
                if (b_valid !== 1'b0) begin
                    errors++; $display("FAIL interleave_latency[%0d] got %b exp 0", cyc, b_valid);
                end
            end else begin
                checks++;
                if ({b_valid, b_head, b_tail, b_sel} !== {1'b1, exp_c[cyc-2]}) begin
                    errors++; $display("FAIL interleave_ctrl[%0d] got %b exp %b", cyc - 2,
                        {b_valid, b_head, b_tail, b_sel}, {1'b1, exp_c[cyc-2]});
                end
                checks++;
                if (b_data !== exp_d[cyc-2]) begin
                    errors++; $display("FAIL interleave_data[%0d] got %h exp %h", cyc - 2, b_data, exp_d[cyc-2]);
                end
            end
        end
        ch_b = el_idle();
        step();
        checks++;
        if (b_err !== 4'b0000) begin
            errors++; $display("FAIL interleave_no_error got %b exp 0000", b_err);
        end
    endtask

    task automatic test_error_sticky();
        send_a(el_flit(1, 1'b0, 0, 30));
        checks++;
        if ({a_valid, a_head, a_tail, a_sel} !== {3'b101, onehot(1)}) begin
            errors++; $display("FAIL stray_body_ctrl got %b exp %b", {a_valid, a_head, a_tail, a_sel}, {3'b101, onehot(1)});
        end
        step();
        checks++;
        if ({a_err, a_evt} !== {onehot(1), 1'b1}) begin
            errors++; $display("FAIL stray_body_error got %b exp %b", {a_err, a_evt}, {onehot(1), 1'b1});
        end
        step();
        checks++;
        if ({a_err, a_evt} !== {onehot(1), 1'b0}) begin
            errors++; $display("FAIL event_pulse got %b exp %b", {a_err, a_evt}, {onehot(1), 1'b0});
        end
        send_a(el_flit(1, 1'b0, 0, 31));
        error_clear = 1'b1;
        step();
        error_clear = 1'b0;
        checks++;
        if ({a_err, a_evt} !== {onehot(1), 1'b1}) begin
            errors++; $display("FAIL clear_vs_set got %b exp %b", {a_err, a_evt}, {onehot(1), 1'b1});
        end
        error_clear = 1'b1;
        step();
        error_clear = 1'b0;
        checks++;
        if ({a_err, a_evt} !== 5'b0) begin
            errors++; $display("FAIL clear_only got %b exp 00000", {a_err, a_evt});
        end
    endtask

    task automatic test_head_restart();
        send_a(el_flit(0, 1'b1, 3, 40));
        send_a(el_flit(0, 1'b0, 0, 41));
        checks++;
        if ({a_head, a_tail} !== 2'b00) begin
            errors++; $display("FAIL restart_first_body got %b exp 00", {a_head, a_tail});
        end
        send_a(el_flit(0, 1'b1, 1, 42));
        checks++;
        if ({a_valid, a_head, a_tail} !== 3'b110) begin
            errors++; $display("FAIL restart_head got %b exp 110", {a_valid, a_head, a_tail});
        end
        send_a(el_flit(0, 1'b0, 0, 43));
        checks++;
        if ({a_tail, a_evt} !== 2'b01) begin
            errors++; $display("FAIL restart_body1 got %b exp 01", {a_tail, a_evt});
        end
        send_a(el_flit(0, 1'b0, 0, 44));
        checks++;
        if (a_tail !== 1'b1) begin
            errors++; $display("FAIL restart_body2_tail got %b exp 1", a_tail);
        end
        step();
        checks++;
        if (a_err !== onehot(0)) begin
            errors++; $display("FAIL restart_error_ivc got %b exp %b", a_err, onehot(0));
        end
    endtask

    task automatic test_min0();
        send_c(el_flit(1, 1'b1, 0, 50));
        checks++;
        if ({c_valid, c_head, c_tail, c_sel} !== {3'b111, onehot(1)}) begin
            errors++; $display("FAIL min0_len0 got %b exp %b", {c_valid, c_head, c_tail, c_sel}, {3'b111, onehot(1)});
        end
        send_c(el_flit(1, 1'b1, 2, 51));
        checks++;
        if ({c_head, c_tail} !== 2'b10) begin
            errors++; $display("FAIL min0_len2_head got %b exp 10", {c_head, c_tail});
        end
        send_c(el_flit(1, 1'b0, 0, 52));
        send_c(el_flit(1, 1'b0, 0, 53));
        checks++;
        if (c_tail !== 1'b1) begin
            errors++; $display("FAIL min0_len2_tail got %b exp 1", c_tail);
        end
        step();
        checks++;
        if (c_err !== 4'b0000) begin
            errors++; $display("FAIL min0_no_error got %b exp 0000", c_err);
        end
        send_c(el_flit(3, 1'b1, 3, 54));
        checks++;
        if ({c_head, c_tail} !== 2'b10) begin
            errors++; $display("FAIL lenerr_head got %b exp 10", {c_head, c_tail});
        end
        send_c(el_flit(3, 1'b0, 0, 55));
        checks++;
        if (c_tail !== 1'b0) begin
            errors++; $display("FAIL lenerr_body1 got %b exp 0", c_tail);
        end
        send_c(el_flit(3, 1'b0, 0, 56));
        checks++;
        if (c_tail !== 1'b1) begin
            errors++; $display("FAIL lenerr_body2 got %b exp 1", c_tail);
        end
        step();
        checks++;
        if (c_err !== onehot(3)) begin
            errors++; $display("FAIL lenerr_error_ivc got %b exp %b", c_err, onehot(3));
        end
    endtask

    task automatic test_headtail();
        send_d(ht_flit(1, 1'b1, 1'b0, 60));
        checks++;
        if ({d_valid, d_head, d_tail, d_sel, d_tivc} !== {3'b110, onehot(1), 4'b0000}) begin
            errors++; $display("FAIL ht_head got %b", {d_valid, d_head, d_tail, d_sel, d_tivc});
        end
        send_d(ht_flit(1, 1'b0, 1'b0, 61));
        checks++;
        if ({d_head, d_tail} !== 2'b00) begin
            errors++; $display("FAIL ht_body got %b exp 00", {d_head, d_tail});
        end
        send_d(ht_flit(1, 1'b0, 1'b1, 62));
        checks++;
        if ({d_tail, d_tivc, d_data} !== {1'b1, 4'b1111, mk_data(62, 0)}) begin
            errors++; $display("FAIL ht_tail got %b %b %h", d_tail, d_tivc, d_data);
        end
        send_d(ht_flit(3, 1'b1, 1'b1, 63));
        send_d(ht_flit(3, 1'b0, 1'b0, 64));
        checks++;
        if (d_tail !== 1'b1) begin
            errors++; $display("FAIL ht_stray_tail got %b exp 1", d_tail);
        end
        step();
        checks++;
        if (d_err !== onehot(3)) begin
            errors++; $display("FAIL ht_error_ivc got %b exp %b", d_err, onehot(3));
        end
    endtask

    task automatic test_active();
        error_clear = 1'b1;
        step();
        error_clear = 1'b0;
        send_a(el_flit(0, 1'b0, 0, 70));
        active = 1'b0;
        repeat (2) step();
        checks++;
        if ({a_valid, a_err, a_evt} !== 6'b100000) begin
            errors++; $display("FAIL inactive_hold got %b exp 100000", {a_valid, a_err, a_evt});
        end
        active = 1'b1;
        step();
        checks++;
        if ({a_valid, a_err} !== {1'b0, onehot(0)}) begin
            errors++; $display("FAIL reactivate got %b exp %b", {a_valid, a_err}, {1'b0, onehot(0)});
        end
    endtask

    task automatic test_reset_mid();
        send_a(el_flit(2, 1'b1, 3, 80));
        send_a(el_flit(2, 1'b0, 0, 81));
        send_a(el_flit(2, 1'b0, 0, 82));
        reset = 1'b1;
        #1;
        checks++;
        if ({a_valid, a_err} !== 5'b0) begin
            errors++; $display("FAIL reset_mid_async got %b exp 00000", {a_valid, a_err});
        end
        #2;
        reset = 1'b0;
        repeat (2) step();
        send_a(el_flit(2, 1'b0, 0, 83));
        checks++;
        if ({a_valid, a_tail} !== 2'b11) begin
            errors++; $display("FAIL post_reset_body got %b exp 11", {a_valid, a_tail});
        end
        step();
        checks++;
        if (a_err !== onehot(2)) begin
            errors++; $display("FAIL post_reset_error got %b exp %b", a_err, onehot(2));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        active      = 1'b1;
        error_clear = 1'b0;
        ch_a = el_idle();
        ch_b = el_idle();
        ch_c = el_idle();
        ch_d = {1'b1, 69'h0};
        test_reset();
        test_len3();
        test_interleave();
        test_error_sticky();
        test_head_restart();
        test_min0();
        test_headtail();
        test_active();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
